timestamp_uart_rx: RTL and testbench
====================================

// Module: timestamp_uart_rx
// PURPOSE
//  UART receiver and line parser for the ASCII timestamp stream: 8 hex digits, CR, LF, 8N1, LSB first.
//  Recovers bytes from RXD_i and assembles the digits MSB-nibble first into a 32-bit word.
//  Publishes the word on CR. Sits at the host/bench end of the timestamp TXD line.
// PARAMETERS
//  C_FCK        48_000_000  system clock frequency [Hz]
//  C_BAUD_RATE  19_200      line rate [bit/s]; C_DIV_LEN = C_FCK/C_BAUD_RATE clocks per bit, must be >= 4
// PORTS
//  CK_i          in   1   system clock
//  RST_i         in   1   reset: one clock, synchronous, active-high
//  CK_EE_i       in   1   clock enable; 0 => every register holds and pulse outputs are 0
//  RXD_i         in   1   serial input, idle high, asynchronous to CK_i
//  BYTE_o        out  8   last good received byte
//  BYTE_VALID_o  out  1   1-cycle pulse: BYTE_o updated
//  FRAME_ERR_o   out  1   1-cycle pulse: stop bit sampled low
//  TIMESTAMPs_o  out  32  last accepted timestamp
//  VALID_o       out  1   1-cycle pulse: TIMESTAMPs_o updated
//  FMT_ERR_o     out  1   1-cycle pulse: line rejected at CR (digit count != 8 or bad char)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; digit count 0; bad-line flag 0; RXD sync FFs 1. RST_i wins over CK_EE_i.
//  RXD_i passes a 2-FF synchroniser (rxd_s); all decisions use rxd_s.
//  Bit FSM (counter PCTR, 0..C_DIV_LEN-1; BIT_CTR, 0..7):
//   IDLE : on rxd_s 1->0, load PCTR and go to START.
//   START: after C_DIV_LEN/2 clocks, sample. rxd_s=0 => DATA, PCTR restart. rxd_s=1 => IDLE (glitch, no output).
//   DATA : sample every C_DIV_LEN clocks, shift right (LSB first). After 8 samples => STOP.
//   STOP : sample after C_DIV_LEN clocks.
//          rxd_s=1 => BYTE_o <= data and BYTE_VALID_o=1 in the next cycle; then IDLE.
//          rxd_s=0 => FRAME_ERR_o=1, byte discarded; go to BREAK.
//   BREAK: wait for rxd_s=1, then IDLE (a held-low line yields exactly one FRAME_ERR_o).
//  Line parser (acts only on BYTE_VALID_o cycles):
//   hex '0'-'9','A'-'F','a'-'f': ACC <= {ACC[27:0],nibble}; DCNT saturates at 9.
//   CR 8'h0D: if DCNT==8 and no bad char => TIMESTAMPs_o <= ACC, VALID_o=1 next cycle; else FMT_ERR_o=1,
//             TIMESTAMPs_o unchanged. Always clear DCNT, bad flag, ACC.
//   LF 8'h0A: ignored. Any other byte: set bad flag (reported at the next CR).
//  Latency: stop-bit centre sample -> BYTE_VALID_o +1 clk; CR BYTE_VALID_o -> VALID_o/FMT_ERR_o +1 clk.
//   Pin edge -> rxd_s: 2 clk.
//  Extra digits (>8) => DCNT=9 => line rejected at CR. A framing-error byte is not fed to the parser.
//  CK_EE_i low mid-frame: timing stretches; bits are sampled at enabled-clock bit centres.
//  Reset mid-frame: the frame is abandoned; the next start edge is taken only after rxd_s has been seen
//   high (IDLE requires a 1->0 transition).
// STRUCTURE
//  timestamp_pkg.vh (`include): C_ASC_CR=8'h0D, C_ASC_LF=8'h0A, FSM state encodings, f_ASC2HEX (returns
//   {is_hex,nibble}) -- shared with the transmitter side's f_HEX2ASC.
//  Sub-module uart_rx_byte: synchroniser + bit FSM (IDLE/START/DATA/STOP/BREAK),
//   outputs BYTE_o/BYTE_VALID_o/FRAME_ERR_o.
//  Top: line parser (ACC, DCNT, bad flag, TIMESTAMPs_o).
// TESTING (C_FCK=10_000, C_BAUD_RATE=300 => C_DIV_LEN=33; bench drives ideal 8N1)
//  1 "0123ABCD\r\n" -> TIMESTAMPs_o=32'h0123ABCD, exactly one VALID_o pulse 1 clk after CR's BYTE_VALID_o;
//    10 BYTE_VALID_o pulses; no error pulses.
//  2 "deadbeef\r" then "0000001\r" -> 32'hDEADBEEF, then FMT_ERR_o pulse; TIMESTAMPs_o stays DEADBEEF.
//  3 "12G45678\r" and "123456789\r" -> one FMT_ERR_o each, no VALID_o; then "FFFFFFFF\r" -> 32'hFFFFFFFF.
//  4 Byte 8'h41 sent with stop bit low -> FRAME_ERR_o once, no BYTE_VALID_o; line held low 5 bit times
//    -> no further pulses; next good byte accepted.
//  5 Low glitch of 10 clk (< 16) on idle line -> no outputs. Assert RST_i mid-DATA -> outputs 0;
//    next full line decodes correctly.
//  6 CK_EE_i toggled 1/0 each clock, C_DIV_LEN timed in enabled clocks -> same results as scenario 1.

Source files
------------

// File: rtl/timestamp_uart_rx_pkg.sv
// Shared definitions for the ASCII timestamp line: control characters,
// receiver bit-FSM states and hex/ASCII conversion helpers. The transmitter
// side uses f_hex2asc, and this receiver uses f_asc2hex.
package timestamp_uart_rx_pkg;

    localparam logic [7:0] C_ASC_CR = 8'h0D;
    localparam logic [7:0] C_ASC_LF = 8'h0A;

    // Byte receiver states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Returns {is_hex, nibble}; nibble is 0 when the character is not hex.
    function automatic logic [4:0] f_asc2hex(input logic [7:0] c);
        logic [3:0] nib;
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            nib = c[3:0] + 4'd9;
            return {1'b1, nib};
        end else begin
            return 5'b0_0000;
        end
    endfunction

    // Upper-case ASCII hex digit for a nibble.
    function automatic logic [7:0] f_hex2asc(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'b0000, n};
        end else begin
            return 8'h37 + {4'b0000, n};
        end
    endfunction

endpackage

// File: rtl/timestamp_uart_rx_if.sv
// Bus bundle of the timestamp receiver.
//   CK_EE_i       clock enable (master -> slave)
//   RXD_i         serial line, idle high (master -> slave)
//   BYTE_o        last good received byte
//   BYTE_VALID_o  1-cycle pulse, BYTE_o updated
//   FRAME_ERR_o   1-cycle pulse, stop bit sampled low
//   TIMESTAMPs_o  last accepted timestamp
//   VALID_o       1-cycle pulse, TIMESTAMPs_o updated
//   FMT_ERR_o     1-cycle pulse, line rejected at CR
interface timestamp_uart_rx_if;

    logic        CK_EE_i;
    logic        RXD_i;
    logic [7:0]  BYTE_o;
    logic        BYTE_VALID_o;
    logic        FRAME_ERR_o;
    logic [31:0] TIMESTAMPs_o;
    logic        VALID_o;
    logic        FMT_ERR_o;

    modport slave (
        input  CK_EE_i,
        input  RXD_i,
        output BYTE_o,
        output BYTE_VALID_o,
        output FRAME_ERR_o,
        output TIMESTAMPs_o,
        output VALID_o,
        output FMT_ERR_o
    );

    modport master (
        output CK_EE_i,
        output RXD_i,
        input  BYTE_o,
        input  BYTE_VALID_o,
        input  FRAME_ERR_o,
        input  TIMESTAMPs_o,
        input  VALID_o,
        input  FMT_ERR_o
    );

endinterface

// File: rtl/timestamp_uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser on RXD_i plus the bit FSM
// (IDLE/START/DATA/STOP/BREAK).
//   CK_i, RST_i   clock, synchronous active-high reset
//   CK_EE_i       clock enable; low => all registers hold, pulses read 0
//   RXD_i         asynchronous serial input, idle high
//   BYTE_o        last good byte
//   BYTE_VALID_o  1-cycle pulse, BYTE_o updated
//   FRAME_ERR_o   1-cycle pulse, stop bit sampled low
module timestamp_uart_rx_byte #(
    parameter int unsigned C_DIV_LEN = 2500
) (
    input  logic       CK_i,
    input  logic       RST_i,
    input  logic       CK_EE_i,
    input  logic       RXD_i,
    output logic [7:0] BYTE_o,
    output logic       BYTE_VALID_o,
    output logic       FRAME_ERR_o
);
    import timestamp_uart_rx_pkg::*;

    localparam int unsigned     C_PW        = (C_DIV_LEN > 1) ? $clog2(C_DIV_LEN) : 1;
    localparam logic [C_PW-1:0] C_LAST      = C_PW'(C_DIV_LEN - 1);
    localparam logic [C_PW-1:0] C_HALF_LAST = C_PW'(C_DIV_LEN / 2 - 1);

    rx_state_e       state_q;
    logic            rxd_m_q;     // metastability stage
    logic            rxd_s_q;     // synchronised line
    logic            rxd_p_q;     // previous rxd_s, for falling-edge detection
    logic [C_PW-1:0] pctr_q;
    logic [2:0]      bit_ctr_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state_q      <= ST_IDLE;
            rxd_m_q      <= 1'b1;
            rxd_s_q      <= 1'b1;
            rxd_p_q      <= 1'b1;
            pctr_q       <= '0;
            bit_ctr_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else if (CK_EE_i) begin
            rxd_m_q      <= RXD_i;
            rxd_s_q      <= rxd_m_q;
            rxd_p_q      <= rxd_s_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A start needs a real 1->0 transition of the synchronised line
                    if (rxd_p_q && !rxd_s_q) begin
                        pctr_q  <= '0;
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (pctr_q == C_HALF_LAST) begin
                        pctr_q    <= '0;
                        bit_ctr_q <= '0;
                        // Line back high at mid start bit: treat as a glitch
                        state_q   <= rxd_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        pctr_q <= pctr_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (pctr_q == C_LAST) begin
                        pctr_q  <= '0;
                        shift_q <= {rxd_s_q, shift_q[7:1]};
                        if (bit_ctr_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_ctr_q <= bit_ctr_q + 1'b1;
                        end
                    end else begin
                        pctr_q <= pctr_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (pctr_q == C_LAST) begin
                        pctr_q <= '0;
                        if (rxd_s_q) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        pctr_q <= pctr_q + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // Swallow a held-low line so it reports a single frame error
                    if (rxd_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pulse flops only clear on enabled cycles, so gating with the enable
    // shows each pulse for exactly one enabled cycle.
    assign BYTE_o       = byte_q;
    assign BYTE_VALID_o = byte_valid_q & CK_EE_i;
    assign FRAME_ERR_o  = frame_err_q & CK_EE_i;

endmodule

// File: rtl/timestamp_uart_rx.sv
// UART receiver and line parser for the ASCII timestamp stream
// (8 hex digits, CR, LF; 8N1, LSB first). Digits are assembled MSB nibble
// first and the word is published on CR.
//   CK_i   system clock
//   RST_i  synchronous active-high reset (wins over CK_EE_i)
//   bus    timestamp_uart_rx_if.slave: CK_EE_i, RXD_i in; BYTE_o,
//          BYTE_VALID_o, FRAME_ERR_o, TIMESTAMPs_o, VALID_o, FMT_ERR_o out
module timestamp_uart_rx #(
    parameter int unsigned C_FCK       = 48_000_000,
    parameter int unsigned C_BAUD_RATE = 19_200
) (
    input  logic                 CK_i,
    input  logic                 RST_i,
    timestamp_uart_rx_if.slave   bus
);
    import timestamp_uart_rx_pkg::*;

    localparam int unsigned C_DIV_LEN = C_FCK / C_BAUD_RATE;

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_frame_err;

    timestamp_uart_rx_byte #(
        .C_DIV_LEN (C_DIV_LEN)
    ) u_byte (
        .CK_i         (CK_i),
        .RST_i        (RST_i),
        .CK_EE_i      (bus.CK_EE_i),
        .RXD_i        (bus.RXD_i),
        .BYTE_o       (rx_byte),
        .BYTE_VALID_o (rx_byte_valid),
        .FRAME_ERR_o  (rx_frame_err)
    );

    assign bus.BYTE_o       = rx_byte;
    assign bus.BYTE_VALID_o = rx_byte_valid;
    assign bus.FRAME_ERR_o  = rx_frame_err;

    logic [31:0] acc_q,     acc_d;
    logic [3:0]  dcnt_q,    dcnt_d;
    logic        bad_q,     bad_d;
    logic [31:0] ts_q,      ts_d;
    logic        valid_q,   valid_d;
    logic        fmt_err_q, fmt_err_d;
    logic [4:0]  hex;

    always_comb begin
        acc_d     = acc_q;
        dcnt_d    = dcnt_q;
        bad_d     = bad_q;
        ts_d      = ts_q;
        valid_d   = 1'b0;
        fmt_err_d = 1'b0;
        hex       = f_asc2hex(rx_byte);

        if (rx_byte_valid) begin
            if (hex[4]) begin
                acc_d = {acc_q[27:0], hex[3:0]};
                // Saturating at 9 keeps "too many digits" distinguishable from 8
                if (dcnt_q != 4'd9) begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end else if (rx_byte == C_ASC_CR) begin
                if (dcnt_q == 4'd8 && !bad_q) begin
                    ts_d    = acc_q;
                    valid_d = 1'b1;
                end else begin
                    fmt_err_d = 1'b1;
                end
                acc_d  = '0;
                dcnt_d = '0;
                bad_d  = 1'b0;
            end else if (rx_byte != C_ASC_LF) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            acc_q     <= '0;
            dcnt_q    <= '0;
            bad_q     <= 1'b0;
            ts_q      <= '0;
            valid_q   <= 1'b0;
            fmt_err_q <= 1'b0;
        end else if (bus.CK_EE_i) begin
            acc_q     <= acc_d;
            dcnt_q    <= dcnt_d;
            bad_q     <= bad_d;
            ts_q      <= ts_d;
            valid_q   <= valid_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    assign bus.TIMESTAMPs_o = ts_q;
    assign bus.VALID_o      = valid_q & bus.CK_EE_i;
    assign bus.FMT_ERR_o    = fmt_err_q & bus.CK_EE_i;

endmodule

// File: tb/tb_timestamp_uart_rx.sv
// Self-checking bench for timestamp_uart_rx (C_DIV_LEN = 10_000/300 = 33).
// Stimulus drives ideal 8N1 frames; expected bytes and line results are
// queued when driven and compared when the DUT pulses.
module tb_timestamp_uart_rx;

    localparam int DIV = 10_000 / 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timestamp_uart_rx_if bus ();

    timestamp_uart_rx #(
        .C_FCK       (10_000),
        .C_BAUD_RATE (300)
    ) dut (
        .CK_i  (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          is_fmt;
        logic [31:0] ts;
    } ev_t;

    logic [7:0] exp_bytes[$];
    ev_t        exp_evs[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cr_cyc   = 0;
    int bv_cnt   = 0;
    int fe_cnt   = 0;
    int val_cnt  = 0;
    int fmt_cnt  = 0;
    bit ce_mode  = 1'b0;

    int b_bv, b_fe, b_val, b_fmt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (bus.BYTE_VALID_o) begin
            bv_cnt++;
            if (bus.BYTE_o == 8'h0D) cr_cyc = cyc;
            if (exp_bytes.size() == 0) begin
                check("byte_unexpected", 32'(bus.BYTE_o), 32'hFFFF_FFFF);
            end else begin
                check("byte", 32'(bus.BYTE_o), 32'(exp_bytes.pop_front()));
            end
        end
        if (bus.FRAME_ERR_o) fe_cnt++;
        if (bus.VALID_o || bus.FMT_ERR_o) begin
            ev_t e;
            if (bus.VALID_o) val_cnt++;
            if (bus.FMT_ERR_o) fmt_cnt++;
            if (exp_evs.size() == 0) begin
                check("event_unexpected", {31'b0, bus.FMT_ERR_o}, 32'hFFFF_FFFF);
            end else begin
                e = exp_evs.pop_front();
                check("event_is_fmt", {31'b0, bus.FMT_ERR_o}, {31'b0, e.is_fmt});
                check("event_is_valid", {31'b0, bus.VALID_o}, {31'b0, ~e.is_fmt});
                check("timestamp", bus.TIMESTAMPs_o, e.ts);
                check("cr_latency", 32'(cyc - cr_cyc), ce_mode ? 32'd2 : 32'd1);
            end
        end
    end

    // One enabled clock edge; in ce_mode a disabled edge precedes it.
    task automatic tick();
        if (ce_mode) begin
            bus.CK_EE_i = 1'b0;
            @(posedge clk);
            #1;
            bus.CK_EE_i = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int extra_low_bits);
        bus.RXD_i = 1'b0;
        ticks(DIV);
        for (int i = 0; i < 8; i++) begin
            bus.RXD_i = b[i];
            ticks(DIV);
        end
        if (stop_val) exp_bytes.push_back(b);
        bus.RXD_i = stop_val;
        ticks(DIV * (1 + extra_low_bits));
        bus.RXD_i = 1'b1;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 0);
        ticks(3 * DIV);
    endtask

    task automatic push_ts(input logic [31:0] ts);
        ev_t e;
        e.is_fmt = 1'b0;
        e.ts     = ts;
        exp_evs.push_back(e);
    endtask

    task automatic push_fmt(input logic [31:0] held_ts);
        ev_t e;
        e.is_fmt = 1'b1;
        e.ts     = held_ts;
        exp_evs.push_back(e);
    endtask

    task automatic snap();
        b_bv  = bv_cnt;
        b_fe  = fe_cnt;
        b_val = val_cnt;
        b_fmt = fmt_cnt;
    endtask

    task automatic check_deltas(input string tag, input int bv, input int fe, input int val, input int fmt);
        check({tag, "_byte_valid_cnt"}, 32'(bv_cnt - b_bv), 32'(bv));
        check({tag, "_frame_err_cnt"},  32'(fe_cnt - b_fe), 32'(fe));
        check({tag, "_valid_cnt"},      32'(val_cnt - b_val), 32'(val));
        check({tag, "_fmt_err_cnt"},    32'(fmt_cnt - b_fmt), 32'(fmt));
        check({tag, "_byteq_empty"},    32'(exp_bytes.size()), 32'd0);
        check({tag, "_evq_empty"},      32'(exp_evs.size()), 32'd0);
    endtask

    initial begin
        bus.CK_EE_i = 1'b1;
        bus.RXD_i   = 1'b1;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte",       32'(bus.BYTE_o), 32'd0);
        check("rst_byte_valid", {31'b0, bus.BYTE_VALID_o}, 32'd0);
        check("rst_frame_err",  {31'b0, bus.FRAME_ERR_o}, 32'd0);
        check("rst_timestamp",  bus.TIMESTAMPs_o, 32'd0);
        check("rst_valid",      {31'b0, bus.VALID_o}, 32'd0);
        check("rst_fmt_err",    {31'b0, bus.FMT_ERR_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(2 * DIV);

        // 1: basic line
        snap();
        push_ts(32'h0123ABCD);
        send_line("0123ABCD\r\n");
        check_deltas("s1", 10, 0, 1, 0);
        check("s1_ts", bus.TIMESTAMPs_o, 32'h0123ABCD);

        // 2: lower-case line, then short line rejected
        snap();
        push_ts(32'hDEADBEEF);
        send_line("deadbeef\r");
        push_fmt(32'hDEADBEEF);
        send_line("0000001\r");
        check_deltas("s2", 17, 0, 1, 1);
        check("s2_ts_held", bus.TIMESTAMPs_o, 32'hDEADBEEF);

        // 3: bad char, too many digits, then all-F
        snap();
        push_fmt(32'hDEADBEEF);
        send_line("12G45678\r");
        push_fmt(32'hDEADBEEF);
        send_line("123456789\r");
        push_ts(32'hFFFFFFFF);
        send_line("FFFFFFFF\r");
        check_deltas("s3", 28, 0, 1, 2);
        check("s3_ts", bus.TIMESTAMPs_o, 32'hFFFFFFFF);

        // 4: framing error then held-low line, then a good byte
        snap();
        send_frame(8'h41, 1'b0, 5);
        ticks(2 * DIV);
        check_deltas("s4_fe", 0, 1, 0, 0);
        snap();
        send_frame(8'h0A, 1'b1, 0);
        ticks(2 * DIV);
        check_deltas("s4_good", 1, 0, 0, 0);
        check("s4_byte", 32'(bus.BYTE_o), 32'h0A);

        // 5: short glitch, reset mid-DATA, then a full line
        snap();
        bus.RXD_i = 1'b0;
        ticks(10);
        bus.RXD_i = 1'b1;
        ticks(3 * DIV);
        check_deltas("s5_glitch", 0, 0, 0, 0);
        bus.RXD_i = 1'b0;
        ticks(DIV);
        bus.RXD_i = 1'b1;
        ticks(3 * DIV);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s5_rst_ts",   bus.TIMESTAMPs_o, 32'd0);
        check("s5_rst_byte", 32'(bus.BYTE_o), 32'd0);
        ticks(8 * DIV);
        check_deltas("s5_rst", 0, 0, 0, 0);
        snap();
        push_ts(32'h89ABCDEF);
        send_line("89abcdef\r\n");
        check_deltas("s5_line", 10, 0, 1, 0);
        check("s5_ts", bus.TIMESTAMPs_o, 32'h89ABCDEF);

        // 6: clock enable toggling every clock
        ce_mode = 1'b1;
        ticks(2 * DIV);
        snap();
        push_ts(32'h0123ABCD);
        send_line("0123ABCD\r\n");
        check_deltas("s6", 10, 0, 1, 0);
        check("s6_ts", bus.TIMESTAMPs_o, 32'h0123ABCD);
        ce_mode = 1'b0;
        bus.CK_EE_i = 1'b1;
        ticks(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
